regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter NUM_REGS, default 32: number of architectural registers; index width is 5 bits.
REQ-003 Parameter DATA_W, default 64: register width; it matches the 64-bit ALU operand width.
REQ-004 Ports, clock and reset first:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rs1  input  5  read address, port 1.
- rs2  input  5  read address, port 2.
- read_data1  output  64  operand a to the ALU.
- read_data2  output  64  operand b to the ALU.
- rs1_busy  output  1  rs1 has an outstanding write.
- rs2_busy  output  1  rs2 has an outstanding write.
- issue_valid  input  1  an instruction targeting issue_rd is issued this cycle.
- issue_rd  input  5  destination of the issued instruction.
- reg_write  input  1  writeback strobe.
- rd  input  5  writeback address.
- write_data  input  64  writeback value, normally the ALU result.

Function
REQ-005 Storage SHALL be NUM_REGS x DATA_W registers, plus a NUM_REGS-bit busy vector.
REQ-006 Reads SHALL be combinational from rs1 and rs2, with zero-cycle latency.
REQ-007 Register 0 SHALL read as 0 with busy 0 at all times; writes and issues to index 0 are ignored.
REQ-008 When reg_write=1 and rd!=0, write_data SHALL be stored in register rd at the rising edge, with one-cycle write latency.
REQ-009 When reg_write=1 and rd!=0, busy[rd] SHALL be cleared at the rising edge.
REQ-010 When issue_valid=1 and issue_rd!=0, busy[issue_rd] SHALL be set at the rising edge.
REQ-011 When set and clear target the same index in the same cycle, set SHALL win: the register holds the new data and stays busy for the newer producer.
REQ-012 Set and clear on different indices in the same cycle SHALL both take effect.
REQ-013 Issuing to an already-busy register SHALL keep it busy with no error; only one outstanding producer per register is tracked.
REQ-014 Writeback to a non-busy register SHALL still write the data, and busy stays 0.
REQ-015 rs1_busy SHALL equal busy[rs1] and rs2_busy SHALL equal busy[rs2], subject to REQ-007 and REQ-019.
REQ-016 rs1 and rs2 may be equal; both ports SHALL return identical values.

Reset
REQ-017 When rst_n=0, all registers and all busy bits SHALL clear to 0 asynchronously, independent of clk.
REQ-018 While rst_n=0, read_data1, read_data2, rs1_busy and rs2_busy SHALL be 0; writes and issues in flight are discarded. Normal operation resumes at the first rising edge after deassertion.

Configuration
REQ-019 Macro REGFILE_BYPASS_EN SHALL be the only configuration feature.
- Defined: when reg_write=1, rd!=0 and rd equals rs1 (or rs2) in the same cycle, that read port returns write_data combinationally, and its busy output is 0 unless issue_valid=1 with issue_rd equal to that address in the same cycle.
- Undefined: read ports return the stored value only, and busy outputs reflect the stored busy vector; the write is visible from the next cycle.

Verification
REQ-020 Reset test: assert rst_n=0 mid-run after writing x5=0xDEAD -> read x5 returns 0 immediately and rs1_busy=0, without waiting for a clock.
REQ-021 Write/read test: write rd=3, data=0x0123_4567_89AB_CDEF, then read rs1=3 next cycle -> read_data1=0x0123456789ABCDEF. Write rd=0, data=0xFFFF -> read x0 returns 0.
REQ-022 Scoreboard test: issue issue_rd=7 in cycle N -> rs2=7 gives rs2_busy=1 from N+1. Writeback rd=7, data=42 in cycle M -> rs2_busy=0 and read_data2=42 from M+1.
REQ-023 Simultaneous events: same cycle issue_rd=9 and rd=9 with data=5 -> next cycle x9=5 and busy=1. Same cycle issue_rd=4 and rd=6 -> busy[4]=1 and busy[6]=0.
REQ-024 Bypass test: rs1=rd=10, reg_write=1, write_data=0x77 in the same cycle -> with REGFILE_BYPASS_EN, read_data1=0x77 in that cycle; without it, read_data1 holds the old value and becomes 0x77 next cycle.
REQ-025 Dual-port alias: rs1=rs2=12 holding 0x1 -> read_data1=read_data2=0x1, and both busy outputs are identical.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file with a per-register busy scoreboard: two combinational read ports, one write port, one issue port.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback data to matching read ports.
module regfile_scoreboard #(
  parameter  int NUM_REGS = 32,
  parameter  int DATA_W   = 64,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     rs1,
  input  logic [AW-1:0]     rs2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_rd,
  input  logic              reg_write,
  input  logic [AW-1:0]     rd,
  input  logic [DATA_W-1:0] write_data
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                wr_en;
  logic                iss_en;
  logic                hit1;
  logic                hit2;

  // Index 0 is hardwired: never written, never marked busy.
  assign wr_en  = reg_write   && (rd != '0);
  assign iss_en = issue_valid && (issue_rd != '0);

  // NOTE: in combinational blocks, blocking assignments in order let the later
  // statement override; placing the set after the clear makes a new producer win.
  always_comb begin
    busy_d = busy_q;
    if (wr_en)  busy_d[rd]       = 1'b0;
    if (iss_en) busy_d[issue_rd] = 1'b1;
  end

  // NOTE: the storage array is reset on purpose, because the architectural state
  // must read as zero the instant reset asserts; most RAM-like arrays should not be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      if (wr_en) regs_q[rd] <= write_data;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Gated by rst_n so in-flight writes are not forwarded while in reset.
  assign hit1 = rst_n && wr_en && (rd == rs1);
  assign hit2 = rst_n && wr_en && (rd == rs2);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  always_comb begin
    read_data1 = regs_q[rs1];
    rs1_busy   = busy_q[rs1];
    if (hit1) begin
      read_data1 = write_data;
      rs1_busy   = iss_en && (issue_rd == rs1);
    end
    if (rs1 == '0) begin
      read_data1 = '0;
      rs1_busy   = 1'b0;
    end
  end

  always_comb begin
    read_data2 = regs_q[rs2];
    rs2_busy   = busy_q[rs2];
    if (hit2) begin
      read_data2 = write_data;
      rs2_busy   = iss_en && (issue_rd == rs2);
    end
    if (rs2 == '0) begin
      read_data2 = '0;
      rs2_busy   = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: a driver pushes expected read-port values
// computed from an array model; a negedge monitor pops and compares.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0, issue_rd = '0, rd = '0;
  logic        issue_valid = 1'b0, reg_write = 1'b0;
  logic [63:0] write_data = '0;
  logic [63:0] read_data1, read_data2;
  logic        rs1_busy, rs2_busy;

  regfile_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rs1         (rs1),
    .rs2         (rs2),
    .read_data1  (read_data1),
    .read_data2  (read_data2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .reg_write   (reg_write),
    .rd          (rd),
    .write_data  (write_data)
  );

  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic        b1;
    logic        b2;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] m_regs [32];
  bit          m_busy [32];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected read value of address a given this cycle's inputs.
  function automatic logic [63:0] m_read(input bit rst, input logic [4:0] a, input bit we,
                                         input logic [4:0] wrd, input logic [63:0] wd);
    if (rst || a == 0) return 64'd0;
    if (BYPASS && we && wrd == a) return wd;
    return m_regs[a];
  endfunction

  function automatic bit m_bsy(input bit rst, input logic [4:0] a, input bit we, input logic [4:0] wrd,
                               input bit iv, input logic [4:0] ird);
    if (rst || a == 0) return 1'b0;
    if (BYPASS && we && wrd == a) return iv && ird == a;
    return m_busy[a];
  endfunction

  task automatic step(input bit rst, input logic [4:0] a1, input logic [4:0] a2,
                      input bit iv, input logic [4:0] ird,
                      input bit we, input logic [4:0] wrd, input logic [63:0] wd,
                      input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = ~rst; rs1 = a1; rs2 = a2;
    issue_valid = iv; issue_rd = ird;
    reg_write = we; rd = wrd; write_data = wd;
    e.rd1 = m_read(rst, a1, we, wrd, wd);
    e.rd2 = m_read(rst, a2, we, wrd, wd);
    e.b1  = m_bsy(rst, a1, we, wrd, iv, ird);
    e.b2  = m_bsy(rst, a2, we, wrd, iv, ird);
    e.tag = tag;
    exp_q.push_back(e);
    // Architectural effect at the coming edge (or immediately, for reset).
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (we && wrd != 0) begin
        m_regs[wrd] = wd;
        m_busy[wrd] = 1'b0;
      end
      if (iv && ird != 0) m_busy[ird] = 1'b1;
    end
  endtask

  task automatic rd_only(input logic [4:0] a1, input logic [4:0] a2, input string tag);
    step(0, a1, a2, 0, 5'd0, 0, 5'd0, 64'd0, tag);
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(1) == 0) return 5'($urandom_range(31));
    return 5'($urandom_range(3));
  endfunction

  // Monitor: ports are combinational, so every driven cycle presents a result at negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, ".read_data1"}, read_data1, e.rd1);
        check({e.tag, ".read_data2"}, read_data2, e.rd2);
        check({e.tag, ".rs1_busy"},   64'(rs1_busy), 64'(e.b1));
        check({e.tag, ".rs2_busy"},   64'(rs2_busy), 64'(e.b2));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    // Reset state, with activity that must be discarded.
    step(1, 5'd3, 5'd7, 1, 5'd7, 1, 5'd3, 64'hABCD, "reset0");
    step(1, 5'd3, 5'd7, 0, 5'd0, 0, 5'd0, 64'd0, "reset1");
    rd_only(5'd3, 5'd7, "post_reset");

    // Write/read, and write to x0 ignored.
    step(0, 5'd3, 5'd0, 0, 5'd0, 1, 5'd3, 64'h0123_4567_89AB_CDEF, "wr3");
    rd_only(5'd3, 5'd3, "rd3");
    step(0, 5'd0, 5'd3, 1, 5'd0, 1, 5'd0, 64'hFFFF, "wr0");
    rd_only(5'd0, 5'd0, "rd0");

    // Scoreboard issue / writeback.
    step(0, 5'd0, 5'd7, 1, 5'd7, 0, 5'd0, 64'd0, "iss7");
    rd_only(5'd0, 5'd7, "busy7");
    step(0, 5'd0, 5'd7, 0, 5'd0, 1, 5'd7, 64'd42, "wb7");
    rd_only(5'd0, 5'd7, "done7");

    // Same-index set and clear; different-index set and clear.
    step(0, 5'd8, 5'd8, 1, 5'd6, 0, 5'd0, 64'd0, "iss6");
    step(0, 5'd9, 5'd9, 1, 5'd9, 1, 5'd9, 64'd5, "same9");
    rd_only(5'd9, 5'd9, "after9");
    step(0, 5'd4, 5'd6, 1, 5'd4, 1, 5'd6, 64'h66, "diff4_6");
    rd_only(5'd4, 5'd6, "after4_6");
    step(0, 5'd4, 5'd4, 1, 5'd4, 0, 5'd0, 64'd0, "reissue4");
    rd_only(5'd4, 5'd4, "still4");
    step(0, 5'd11, 5'd11, 0, 5'd0, 1, 5'd11, 64'h1111, "wb_notbusy11");
    rd_only(5'd11, 5'd11, "after11");

    // Bypass cycle on x10 (old value 0x11), with and without a same-cycle issue.
    step(0, 5'd0, 5'd0, 0, 5'd0, 1, 5'd10, 64'h11, "pre10");
    step(0, 5'd10, 5'd0, 0, 5'd0, 1, 5'd10, 64'h77, "byp10");
    rd_only(5'd10, 5'd0, "after10");
    step(0, 5'd10, 5'd10, 1, 5'd10, 1, 5'd10, 64'h88, "byp10_iss");
    rd_only(5'd10, 5'd10, "after10_iss");

    // Dual-port alias.
    step(0, 5'd0, 5'd0, 0, 5'd0, 1, 5'd12, 64'h1, "wr12");
    rd_only(5'd12, 5'd12, "alias12");
    step(0, 5'd12, 5'd12, 1, 5'd12, 0, 5'd0, 64'd0, "iss12");
    rd_only(5'd12, 5'd12, "alias12_busy");

    // Mid-run reset clears data and busy without waiting for an edge.
    step(0, 5'd0, 5'd0, 1, 5'd5, 1, 5'd5, 64'hDEAD, "wr5");
    rd_only(5'd5, 5'd12, "pre_rst5");
    step(1, 5'd5, 5'd12, 1, 5'd13, 1, 5'd5, 64'hBEEF, "rst5");
    rd_only(5'd5, 5'd13, "rel5");

    // Randomized traffic with collisions and occasional reset.
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(63) == 0), rnd_addr(), rnd_addr(),
           bit'($urandom_range(1)), rnd_addr(),
           bit'($urandom_range(1)), rnd_addr(), {$urandom, $urandom},
           $sformatf("rand%0d", i));
    end

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
